// File: rtl/oscillator_types_pkg.sv
// Shared oscillator types: waveform encoding and glide controller states.
// Imported by oscillator_core and osc_glide_ctrl.
package oscillator_types_pkg;

    typedef enum logic [1:0] {
        OSC_SQUARE_E   = 2'd0,
        OSC_SAW_E      = 2'd1,
        OSC_TRIANGLE_E = 2'd2,
        OSC_NOISE_E    = 2'd3
    } osc_waveform_type_t;

    typedef enum logic [1:0] {
        OSC_GLIDE_IDLE_E = 2'd0,
        OSC_GLIDE_STEP_E = 2'd1,
        OSC_GLIDE_WAIT_E = 2'd2
    } osc_glide_state_t;

endpackage

// File: rtl/osc_tick_div.sv
// Glide rate divider: counts 0..div_i while enabled, tick_o on terminal count.
// Ports: clk, rst_n, clear_i (sync clear), en_i, div_i (terminal count), tick_o.
module osc_tick_div #(
    parameter int DIV_WIDTH_P = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear_i,
    input  logic                   en_i,
    input  logic [DIV_WIDTH_P-1:0] div_i,
    output logic                   tick_o
);

    localparam logic [DIV_WIDTH_P-1:0] ONE = DIV_WIDTH_P'(1);

    logic [DIV_WIDTH_P-1:0] cnt_q;
    logic [DIV_WIDTH_P-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == div_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/osc_glide_ctrl.sv
// Glides oscillator frequency toward a requested target, then applies waveform/duty at a period wrap.
// Ports: req_* handshake + targets, cr_glide_* config, period_wrap in; cr_* to core, busy, done out.
module osc_glide_ctrl
    import oscillator_types_pkg::*;
#(
    parameter int COUNTER_WIDTH_P = -1,
    parameter int DIV_WIDTH_P     = 16,
    // Guards elaboration when the width has not been overridden.
    localparam int CW = (COUNTER_WIDTH_P > 0) ? COUNTER_WIDTH_P : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_waveform,
    input  logic [CW-1:0]          req_frequency,
    input  logic [CW-1:0]          req_duty_cycle,
    input  logic [CW-1:0]          cr_glide_step,
    input  logic [DIV_WIDTH_P-1:0] cr_glide_div,
    input  logic                   period_wrap,
    output logic [1:0]             cr_waveform_select,
    output logic [CW-1:0]          cr_frequency,
    output logic [CW-1:0]          cr_duty_cycle,
    output logic                   busy,
    output logic                   done
);

    osc_glide_state_t   state_q, state_d;
    osc_waveform_type_t wave_q, wave_d;
    osc_waveform_type_t tgt_wave_q, tgt_wave_d;
    logic [CW-1:0]      freq_q, freq_d;
    logic [CW-1:0]      duty_q, duty_d;
    logic [CW-1:0]      tgt_freq_q, tgt_freq_d;
    logic [CW-1:0]      tgt_duty_q, tgt_duty_d;
    logic [CW-1:0]      step_q, step_d;
    logic [DIV_WIDTH_P-1:0] div_q, div_d;
    logic               done_q, done_d;
    logic               div_clear;
    logic               tick;

    logic [CW:0]   dist_x;
    logic          up;
    logic [CW-1:0] nxt_freq;
    logic [CW-1:0] nxt_duty;
    logic [CW-1:0] fin_duty;

    assign req_ready = (state_q == OSC_GLIDE_IDLE_E);
    assign busy      = !req_ready;

    osc_tick_div #(
        .DIV_WIDTH_P(DIV_WIDTH_P)
    ) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear_i(div_clear),
        .en_i   (state_q == OSC_GLIDE_STEP_E),
        .div_i  (div_q),
        .tick_o (tick)
    );

    // Distance is taken one bit wider; the add/sub below only runs when
    // dist > step, so it can neither overshoot nor wrap.
    always_comb begin
        up     = tgt_freq_q > freq_q;
        dist_x = up ? ({1'b0, tgt_freq_q} - {1'b0, freq_q})
                    : ({1'b0, freq_q} - {1'b0, tgt_freq_q});
        if (dist_x <= {1'b0, step_q}) begin
            nxt_freq = tgt_freq_q;
        end else if (up) begin
            nxt_freq = freq_q + step_q;
        end else begin
            nxt_freq = freq_q - step_q;
        end
        nxt_duty = (duty_q < nxt_freq) ? duty_q : nxt_freq;
        fin_duty = (tgt_duty_q < tgt_freq_q) ? tgt_duty_q : tgt_freq_q;
    end

    always_comb begin
        state_d    = state_q;
        wave_d     = wave_q;
        freq_d     = freq_q;
        duty_d     = duty_q;
        tgt_wave_d = tgt_wave_q;
        tgt_freq_d = tgt_freq_q;
        tgt_duty_d = tgt_duty_q;
        step_d     = step_q;
        div_d      = div_q;
        done_d     = 1'b0;
        div_clear  = 1'b0;
        unique case (1'b1)
            (state_q == OSC_GLIDE_IDLE_E): begin
                if (req_valid) begin
                    tgt_wave_d = osc_waveform_type_t'(req_waveform);
                    tgt_freq_d = req_frequency;
                    tgt_duty_d = req_duty_cycle;
                    step_d     = cr_glide_step;
                    div_d      = cr_glide_div;
                    div_clear  = 1'b1;
                    if (cr_glide_step != '0 && req_frequency != freq_q) begin
                        state_d = OSC_GLIDE_STEP_E;
                    end else begin
                        state_d = OSC_GLIDE_WAIT_E;
                        freq_d  = req_frequency;
                    end
                end
            end
            (state_q == OSC_GLIDE_STEP_E): begin
                if (tick) begin
                    freq_d = nxt_freq;
                    duty_d = nxt_duty;
                    if (nxt_freq == tgt_freq_q) begin
                        state_d = OSC_GLIDE_WAIT_E;
                    end
                end
            end
            (state_q == OSC_GLIDE_WAIT_E): begin
                // A stopped oscillator never wraps, so apply immediately.
                if (period_wrap || freq_q == '0) begin
                    wave_d  = tgt_wave_q;
                    duty_d  = fin_duty;
                    done_d  = 1'b1;
                    state_d = OSC_GLIDE_IDLE_E;
                end
            end
            default: begin
                state_d = OSC_GLIDE_IDLE_E;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= OSC_GLIDE_IDLE_E;
            wave_q     <= OSC_SQUARE_E;
            freq_q     <= '0;
            duty_q     <= '0;
            tgt_wave_q <= OSC_SQUARE_E;
            tgt_freq_q <= '0;
            tgt_duty_q <= '0;
            step_q     <= '0;
            div_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wave_q     <= wave_d;
            freq_q     <= freq_d;
            duty_q     <= duty_d;
            tgt_wave_q <= tgt_wave_d;
            tgt_freq_q <= tgt_freq_d;
            tgt_duty_q <= tgt_duty_d;
            step_q     <= step_d;
            div_q      <= div_d;
            done_q     <= done_d;
        end
    end

    assign cr_waveform_select = wave_q;
    assign cr_frequency       = freq_q;
    assign cr_duty_cycle      = duty_q;
    assign done               = done_q;

endmodule

// File: tb/tb_osc_glide_ctrl.sv
// Directed + randomized bench for osc_glide_ctrl against a transaction-level model.
// Ports: none.
module tb_osc_glide_ctrl;
    import oscillator_types_pkg::*;

    localparam int CW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_waveform;
    logic [CW-1:0] req_frequency;
    logic [CW-1:0] req_duty_cycle;
    logic [CW-1:0] cr_glide_step;
    logic [DW-1:0] cr_glide_div;
    logic          period_wrap;
    logic [1:0]    cr_waveform_select;
    logic [CW-1:0] cr_frequency;
    logic [CW-1:0] cr_duty_cycle;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    // Reference model: what the oscillator is currently programmed with.
    int m_freq = 0;
    int m_duty = 0;
    int m_wave = 0;

    always #5 clk = ~clk;

    osc_glide_ctrl #(
        .COUNTER_WIDTH_P(CW),
        .DIV_WIDTH_P    (DW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_waveform      (req_waveform),
        .req_frequency     (req_frequency),
        .req_duty_cycle    (req_duty_cycle),
        .cr_glide_step     (cr_glide_step),
        .cr_glide_div      (cr_glide_div),
        .period_wrap       (period_wrap),
        .cr_waveform_select(cr_waveform_select),
        .cr_frequency      (cr_frequency),
        .cr_duty_cycle     (cr_duty_cycle),
        .busy              (busy),
        .done              (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // One glide step: close the gap by at most s, landing exactly on t.
    function automatic int glide_next(input int c, input int t, input int s);
        int gap;
        gap = (t > c) ? t - c : c - t;
        if (gap <= s) return t;
        return (t > c) ? c + s : c - s;
    endfunction

    task automatic chk_outs(input string tag);
        chk({tag, "_freq"}, cr_frequency, m_freq);
        chk({tag, "_duty"}, cr_duty_cycle, m_duty);
        chk({tag, "_wave"}, cr_waveform_select, m_wave);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where
    // done is high. With bp set a junk request stays valid while busy.
    task automatic do_req(input int w, input int f, input int d,
                          input int s, input int dv, input int wd,
                          input bit bp, input bit wrap_at_acc);
        chk("ready_idle", req_ready, 1);
        req_valid      = 1'b1;
        req_waveform   = 2'(w);
        req_frequency  = CW'(f);
        req_duty_cycle = CW'(d);
        cr_glide_step  = CW'(s);
        cr_glide_div   = DW'(dv);
        period_wrap    = wrap_at_acc;
        @(negedge clk);
        period_wrap   = 1'b0;
        req_valid     = bp;
        cr_glide_step = CW'($urandom_range(1, 500));
        cr_glide_div  = DW'($urandom_range(0, 15));
        if (bp) begin
            req_waveform   = 2'($urandom);
            req_frequency  = CW'($urandom);
            req_duty_cycle = CW'($urandom);
        end
        chk("acc_done", done, 0);
        chk("acc_busy", busy, 1);
        chk("acc_ready", req_ready, 0);
        if (s == 0 || f == m_freq) begin
            m_freq = f;
            chk_outs("jump");
        end else begin
            while (m_freq != f) begin
                for (int k = 0; k <= dv; k++) begin
                    chk("hold_freq", cr_frequency, m_freq);
                    period_wrap = 1'($urandom);
                    @(negedge clk);
                end
                period_wrap = 1'b0;
                m_freq = glide_next(m_freq, f, s);
                m_duty = imin(m_duty, m_freq);
                chk_outs("step");
                chk("step_busy", busy, 1);
                chk("step_done", done, 0);
                if (bp) chk("bp_ready", req_ready, 0);
            end
        end
        if (f != 0) begin
            for (int k = 0; k < wd; k++) begin
                chk("wait_busy", busy, 1);
                chk("wait_done", done, 0);
                chk("wait_wave", cr_waveform_select, m_wave);
                @(negedge clk);
            end
            period_wrap = 1'b1;
        end
        @(negedge clk);
        period_wrap = 1'b0;
        m_wave = w;
        m_duty = imin(d, f);
        chk_outs("fin");
        chk("fin_done", done, 1);
        chk("fin_busy", busy, 0);
        chk("fin_ready", req_ready, 1);
    endtask

    initial begin
        rst_n          = 1'b0;
        req_valid      = 1'b0;
        req_waveform   = '0;
        req_frequency  = '0;
        req_duty_cycle = '0;
        cr_glide_step  = '0;
        cr_glide_div   = '0;
        period_wrap    = 1'b0;
        repeat (2) @(negedge clk);
        chk_outs("rst");
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Jump with a long wait for the wrap.
        do_req(OSC_TRIANGLE_E, 1000, 500, 0, 0, 20, 0, 0);
        @(negedge clk);
        chk("done_once", done, 0);
        // Glide up 100 -> 130 by 8 every 4 clocks.
        do_req(OSC_SQUARE_E, 100, 50, 0, 0, 2, 0, 0);
        do_req(OSC_SAW_E, 130, 60, 8, 3, 1, 0, 0);
        // Glide down with duty clamp.
        do_req(OSC_SQUARE_E, 200, 180, 0, 0, 0, 0, 0);
        do_req(OSC_SAW_E, 50, 120, 100, 1, 3, 0, 0);
        // Wrap coincident with accept must not complete the update.
        do_req(OSC_SAW_E, 300, 100, 0, 0, 3, 0, 1);
        // Backpressure, then the held request goes in right after done.
        do_req(OSC_TRIANGLE_E, 90, 30, 20, 0, 2, 1, 0);
        do_req(OSC_NOISE_E, 400, 399, 0, 0, 1, 0, 0);
        // Stopped oscillator: no wrap needed.
        do_req(OSC_SQUARE_E, 0, 10, 0, 0, 0, 0, 0);
        do_req(OSC_SAW_E, 37, 5, 7, 2, 0, 0, 0);
        do_req(OSC_TRIANGLE_E, 0, 3, 9, 0, 0, 0, 0);

        for (int n = 0; n < 25; n++) begin
            do_req($urandom_range(0, 3), $urandom_range(0, 300),
                   $urandom_range(0, 400),
                   ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 60),
                   $urandom_range(0, 3), $urandom_range(0, 5),
                   1'($urandom), 1'($urandom));
        end
        req_valid = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of a glide.
        req_valid      = 1'b1;
        req_waveform   = 2'(OSC_SAW_E);
        req_frequency  = CW'(m_freq + 500);
        req_duty_cycle = CW'(77);
        cr_glide_step  = CW'(1);
        cr_glide_div   = '0;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        m_freq = 0;
        m_duty = 0;
        m_wave = 0;
        #1;
        chk_outs("arst");
        chk("arst_done", done, 0);
        chk("arst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 1);
        chk_outs("post_rst");
        do_req(OSC_TRIANGLE_E, 20, 15, 6, 1, 2, 0, 0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
